note_sequencer: RTL and testbench



---
 rtl/sequencer_pkg.sv | 46 ++++
 rtl/beat_timer.sv | 55 +++++
 rtl/note_sequencer.sv | 151 +++++++++++++++
 tb/tb_note_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sequencer_pkg
//   Shared types and constants for the note sequencer:
//     - FRAC_BITS   : Q.20 fixed-point fraction width
//     - RATIO_ROM   : just-intonation ratios for semitones 0..12 (Q.20, truncated)
//     - seq_state_t : sequencer FSM states
//     - note_event_t: one latched note event (tone, duration, cutoff)
// -----------------------------------------------------------------------------
package sequencer_pkg;

  localparam int FRAC_BITS  = 20;
  localparam int NUM_VOICES = 8;

  // Tones at or above this index are rests.
  localparam logic [3:0] REST_MIN = 4'd13;

  localparam logic [31:0] RATIO_ROM [13] = '{
    32'd1048576, 32'd1118481, 32'd1179648, 32'd1258291, 32'd1310720,
    32'd1398101, 32'd1474560, 32'd1572864, 32'd1677721, 32'd1747626,
    32'd1864135, 32'd1966080, 32'd2097152
  };

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MULT,
    PLAY
  } seq_state_t;

  typedef struct packed {
    logic [3:0] tone;
    logic [7:0] duration;
    logic [2:0] cutoff;
  } note_event_t;

  // Ratio for a tone; rests map to 0 so the ROM is never indexed out of range.
  function automatic logic [31:0] ratio_lookup(input logic [3:0] tone);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) begin
      if (tone == 4'(i)) r = RATIO_ROM[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// -----------------------------------------------------------------------------
// beat_timer
//   Two-level down counter timing a note: tick_cnt counts clk cycles within a
//   beat, beat_cnt counts remaining beats. done is high on the final cycle.
//
//   Ports:
//     clk      in  system clock
//     reset    in  synchronous, active-high
//     load     in  load tick_cnt=TICKS_PER_BEAT-1, beat_cnt=duration-1
//     en       in  count one cycle
//     duration in  [7:0] note length in beats (>=1 when loaded)
//     done     out tick_cnt==0 && beat_cnt==0
// -----------------------------------------------------------------------------
module beat_timer #(
  parameter int unsigned TICKS_PER_BEAT = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] duration,
  output logic       done
);

  localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICKS_PER_BEAT - 1);

  logic [TW-1:0] tick_cnt;
  logic [7:0]    beat_cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) begin
      tick_cnt <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      tick_cnt <= TICK_RELOAD;
      beat_cnt <= duration - 8'd1;
    end else if (en) begin
      if (tick_cnt == '0) begin
        // Hold at zero once the last beat expires instead of wrapping.
        if (beat_cnt != '0) begin
          tick_cnt <= TICK_RELOAD;
          beat_cnt <= beat_cnt - 8'd1;
        end
      end else begin
        tick_cnt <= tick_cnt - TW'(1);
      end
    end
  end

  assign done = (tick_cnt == '0) && (beat_cnt == '0);

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Consumes note events, looks up the just-intonation ratio, scales a Q.20
//   base pitch and drives 8 voice frequencies/volumes plus the filter cutoff
//   for duration*TICKS_PER_BEAT cycles.
//
//   Ports:
//     clk           in  system clock
//     reset         in  synchronous, active-high
//     in_valid      in  note event valid
//     in_ready      out sequencer can accept an event (registered)
//     in_tone       in  [3:0] 0..12 semitone above base, 13..15 rest
//     in_duration   in  [7:0] beats; 0 discards the event
//     in_cutoff     in  [2:0] filter cutoff for this note
//     in_detune     in  signed [7:0] (only with NOTE_SEQUENCER_DETUNE_EN)
//     frequencies   out [7:0][31:0] per-voice frequency, Q.20
//     voice_volumes out [7:0][31:0] per-voice volume, Q.20
//     cutoff        out [2:0] filter cutoff
//     note_active   out high while playing a pitched tone
//
//   Optional feature macro: NOTE_SEQUENCER_DETUNE_EN
//     Adds in_detune; odd voices get +sign_extend(detune)<<10.
// -----------------------------------------------------------------------------
module note_sequencer
  import sequencer_pkg::*;
#(
  parameter logic [31:0] BASE_FREQ      = 32'd110 << 20,
  parameter int unsigned TICKS_PER_BEAT = 48000,
  parameter logic [31:0] VOICE_VOLUME   = 32'd1 << 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_tone,
  input  logic [7:0]       in_duration,
  input  logic [2:0]       in_cutoff,
`ifdef NOTE_SEQUENCER_DETUNE_EN
  input  logic signed [7:0] in_detune,
`endif
  output logic [7:0][31:0] frequencies,
  output logic [7:0][31:0] voice_volumes,
  output logic [2:0]       cutoff,
  output logic             note_active
);

  seq_state_t  state;
  note_event_t evt;
  logic [31:0] ratio;
  logic        rest;
  logic [63:0] product;
  logic [31:0] note_freq;
  logic        timer_done;

`ifdef NOTE_SEQUENCER_DETUNE_EN
  logic signed [7:0] detune;
  logic [31:0]       detune_offset;
  assign detune_offset = {{24{detune[7]}}, detune} << 10;
`endif

  // Full 64-bit product, then drop the fraction and truncate to 32 bits.
  assign product   = 64'(BASE_FREQ) * 64'(ratio);
  assign note_freq = 32'(product >> FRAC_BITS);

  beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_beat_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (state == MULT),
    .en      (state == PLAY),
    .duration(evt.duration),
    .done    (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      evt           <= '0;
      ratio         <= '0;
      rest          <= 1'b0;
      frequencies   <= '0;
      voice_volumes <= '0;
      cutoff        <= '0;
      note_active   <= 1'b0;
`ifdef NOTE_SEQUENCER_DETUNE_EN
      detune        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            evt <= '{tone: in_tone, duration: in_duration, cutoff: in_cutoff};
`ifdef NOTE_SEQUENCER_DETUNE_EN
            detune <= in_detune;
`endif
            // A zero-length event is consumed without leaving IDLE.
            if (in_duration != 8'd0) begin
              state    <= LOOKUP;
              in_ready <= 1'b0;
            end
          end
        end

        LOOKUP: begin
          ratio <= ratio_lookup(evt.tone);
          rest  <= (evt.tone >= REST_MIN);
          state <= MULT;
        end

        MULT: begin
          // Outputs are registered here so they appear on the first PLAY cycle.
          cutoff <= evt.cutoff;
          if (rest) begin
            voice_volumes <= '0;
            note_active   <= 1'b0;
          end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
`ifdef NOTE_SEQUENCER_DETUNE_EN
              if (i % 2 == 1)
                frequencies[i] <= (note_freq << (i % 3)) + detune_offset;
              else
                frequencies[i] <= note_freq << (i % 3);
`else
              frequencies[i] <= note_freq << (i % 3);
`endif
              voice_volumes[i] <= VOICE_VOLUME;
            end
            note_active <= 1'b1;
          end
          state <= PLAY;
        end

        PLAY: begin
          if (timer_done) begin
            // Frequencies and cutoff hold so release has no pitch glitch.
            voice_volumes <= '0;
            note_active   <= 1'b0;
            in_ready      <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//   Directed, table-driven bench for note_sequencer with TICKS_PER_BEAT=4.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int TPB = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_tone;
  logic [7:0]       in_duration;
  logic [2:0]       in_cutoff;
  logic [7:0][31:0] frequencies;
  logic [7:0][31:0] voice_volumes;
  logic [2:0]       cutoff;
  logic             note_active;

  int n_checks = 0;
  int n_passed = 0;

  note_sequencer #(
    .BASE_FREQ     (32'd110 << 20),
    .TICKS_PER_BEAT(TPB),
    .VOICE_VOLUME  (32'd1 << 20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tone      (in_tone),
    .in_duration  (in_duration),
    .in_cutoff    (in_cutoff),
    .frequencies  (frequencies),
    .voice_volumes(voice_volumes),
    .cutoff       (cutoff),
    .note_active  (note_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tone;
    logic [7:0]  dur;
    logic [2:0]  cut;
    logic [31:0] f0;
    logic [31:0] f1;
    logic [31:0] f2;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      n_passed++;
  endtask

  // Present an event, wait (bounded) for in_ready, let the handshake edge pass.
  // Returns at the negedge of the LOOKUP cycle with in_valid dropped.
  task automatic send(input logic [3:0] t, input logic [7:0] d, input logic [2:0] c);
    int budget;
    budget = 0;
    in_tone = t; in_duration = d; in_cutoff = c; in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("ready_before_handshake", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count (bounded) negedges with note_active high, starting on a PLAY cycle.
  task automatic count_active(output int cnt);
    cnt = 0;
    while (note_active && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int gap;
    logic [31:0] held_f0;

    vecs[0] = '{tone: 4'd0,  dur: 8'd2, cut: 3'd1, f0: 32'd115343360, f1: 32'd230686720, f2: 32'd461373440};
    vecs[1] = '{tone: 4'd7,  dur: 8'd1, cut: 3'd3, f0: 32'd173015040, f1: 32'd346030080, f2: 32'd692060160};
    vecs[2] = '{tone: 4'd12, dur: 8'd1, cut: 3'd5, f0: 32'd230686720, f1: 32'd461373440, f2: 32'd922746880};
    vecs[3] = '{tone: 4'd4,  dur: 8'd1, cut: 3'd2, f0: 32'd144179200, f1: 32'd288358400, f2: 32'd576716800};
    vecs[4] = '{tone: 4'd5,  dur: 8'd3, cut: 3'd6, f0: 32'd153791110, f1: 32'd307582220, f2: 32'd615164440};

    reset = 1'b1; in_valid = 1'b0; in_tone = '0; in_duration = '0; in_cutoff = '0;

    // Reset held two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",    32'(in_ready),     32'd0);
    check("rst_freq0",       frequencies[0],    32'd0);
    check("rst_freq7",       frequencies[7],    32'd0);
    check("rst_vol0",        voice_volumes[0],  32'd0);
    check("rst_cutoff",      32'(cutoff),       32'd0);
    check("rst_note_active", 32'(note_active),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Table-driven notes.
    foreach (vecs[k]) begin
      send(vecs[k].tone, vecs[k].dur, vecs[k].cut);
      @(negedge clk);
      check("mult_not_active", 32'(note_active), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_freq0", k), frequencies[0], vecs[k].f0);
      check($sformatf("v%0d_freq1", k), frequencies[1], vecs[k].f1);
      check($sformatf("v%0d_freq2", k), frequencies[2], vecs[k].f2);
      check($sformatf("v%0d_freq3", k), frequencies[3], vecs[k].f0);
      check($sformatf("v%0d_freq7", k), frequencies[7], vecs[k].f1);
      check($sformatf("v%0d_vol0", k),  voice_volumes[0], 32'd1048576);
      check($sformatf("v%0d_vol6", k),  voice_volumes[6], 32'd1048576);
      check($sformatf("v%0d_cutoff", k), 32'(cutoff), 32'(vecs[k].cut));
      count_active(cnt);
      check($sformatf("v%0d_active_len", k), 32'(cnt), 32'(vecs[k].dur) * TPB);
      check($sformatf("v%0d_rel_vol", k),   voice_volumes[0], 32'd0);
      check($sformatf("v%0d_rel_freq2", k), frequencies[2], vecs[k].f2);
      check($sformatf("v%0d_rel_cutoff", k), 32'(cutoff), 32'(vecs[k].cut));
    end

    // Back-to-back: tone 7 then tone 12 with the second event held upstream.
    send(4'd7, 8'd1, 3'd3);
    in_valid = 1'b1; in_tone = 4'd12; in_duration = 8'd1; in_cutoff = 3'd5;
    @(negedge clk);
    @(negedge clk);
    check("b2b_t7_freq0", frequencies[0], 32'd173015040);
    count_active(cnt);
    check("b2b_t7_len", 32'(cnt), 32'(TPB));
    gap = 0;
    while (!note_active && gap < 50) begin
      gap++;
      if (gap > 1 && !in_ready) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_gap", 32'(gap), 32'd3);
    check("b2b_t12_freq2", frequencies[2], 32'd922746880);
    check("b2b_t12_cutoff", 32'(cutoff), 32'd5);
    count_active(cnt);
    check("b2b_t12_len", 32'(cnt), 32'(TPB));

    // Rest: tone 14, duration 1. Busy window is LOOKUP+MULT+TPB PLAY cycles.
    held_f0 = 32'd230686720;
    send(4'd14, 8'd1, 3'd7);
    cnt = 1;
    while (!in_ready && cnt < 100) begin
      if (cnt == 3) begin
        check("rest_active", 32'(note_active), 32'd0);
        check("rest_vol", voice_volumes[0], 32'd0);
        check("rest_freq0", frequencies[0], held_f0);
        check("rest_cutoff", 32'(cutoff), 32'd7);
      end
      cnt++;
      @(negedge clk);
    end
    check("rest_busy_len", 32'(cnt - 1), 32'(2 + TPB));

    // Duration 0: consumed, no output change, next event accepted at once.
    send(4'd3, 8'd0, 3'd4);
    check("dur0_ready", 32'(in_ready), 32'd1);
    check("dur0_cutoff", 32'(cutoff), 32'd7);
    check("dur0_freq0", frequencies[0], held_f0);
    check("dur0_active", 32'(note_active), 32'd0);
    send(4'd0, 8'd1, 3'd1);
    check("dur0_next_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("dur0_next_freq0", frequencies[0], 32'd115343360);
    count_active(cnt);
    check("dur0_next_len", 32'(cnt), 32'(TPB));

    // Reset in the middle of PLAY.
    send(4'd7, 8'd2, 3'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_active", 32'(note_active), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_active", 32'(note_active), 32'd0);
    check("midrst_freq0", frequencies[0], 32'd0);
    check("midrst_freq2", frequencies[2], 32'd0);
    check("midrst_vol0", voice_volumes[0], 32'd0);
    check("midrst_cutoff", 32'(cutoff), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", 32'(in_ready), 32'd1);
    send(4'd12, 8'd2, 3'd6);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_freq2", frequencies[2], 32'd922746880);
    count_active(cnt);
    check("post_rst_len", 32'(cnt), 32'(2 * TPB));

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
